// File: rtl/rx_fifo_pkg.sv
// Shared UART receive-path constants, entry layout and helpers used by the
// Rx FIFO and its sub-blocks.
package rx_fifo_pkg;

  localparam int unsigned MAX_UART_DATA_W = 8;
  localparam int unsigned RX_FIFO_ADDR_W  = 4;
  localparam int unsigned ENTRY_W         = MAX_UART_DATA_W + 2;

  // Bit positions of the fields inside one stored entry
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned PERR_BIT = MAX_UART_DATA_W;
  localparam int unsigned SERR_BIT = MAX_UART_DATA_W + 1;

  typedef struct packed {
    logic                       stop_err;
    logic                       parity_err;
    logic [MAX_UART_DATA_W-1:0] data;
  } rx_entry_t;

  function automatic rx_entry_t pack_entry(input logic                       stop_err,
                                           input logic                       parity_err,
                                           input logic [MAX_UART_DATA_W-1:0] data);
    rx_entry_t e;
    e.stop_err   = stop_err;
    e.parity_err = parity_err;
    e.data       = data;
    return e;
  endfunction

endpackage

// File: rtl/rx_fifo_if.sv
// Rx-side push, bus-side pop and status signals of the receive FIFO.
// The slave modport is the FIFO itself; master is whoever drives it.
interface rx_fifo_if #(
  parameter int unsigned FIFO_ADDR_W = rx_fifo_pkg::RX_FIFO_ADDR_W
);
  import rx_fifo_pkg::*;

  logic                       rx_done_i;
  logic [MAX_UART_DATA_W-1:0] rx_data_i;
  logic                       rx_parity_err_i;
  logic                       rx_stop_err_i;
  logic                       rd_en_i;
  logic                       flush_i;
  logic                       ovr_clr_i;
  logic [FIFO_ADDR_W:0]       threshold_i;

  logic [MAX_UART_DATA_W-1:0] rd_data_o;
  logic                       rd_parity_err_o;
  logic                       rd_stop_err_o;
  logic                       empty_o;
  logic                       full_o;
  logic [FIFO_ADDR_W:0]       count_o;
  logic                       level_irq_o;
  logic                       overrun_o;

  modport slave (
    input  rx_done_i, rx_data_i, rx_parity_err_i, rx_stop_err_i,
    input  rd_en_i, flush_i, ovr_clr_i, threshold_i,
    output rd_data_o, rd_parity_err_o, rd_stop_err_o,
    output empty_o, full_o, count_o, level_irq_o, overrun_o
  );

  modport master (
    output rx_done_i, rx_data_i, rx_parity_err_i, rx_stop_err_i,
    output rd_en_i, flush_i, ovr_clr_i, threshold_i,
    input  rd_data_o, rd_parity_err_o, rd_stop_err_o,
    input  empty_o, full_o, count_o, level_irq_o, overrun_o
  );

endinterface

// File: rtl/rx_fifo_ram.sv
// Simple dual-port storage array: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module rx_fifo_ram #(
  parameter int unsigned ENTRY_W     = 10,
  parameter int unsigned FIFO_ADDR_W = 4
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [FIFO_ADDR_W-1:0] waddr_i,
  input  logic [ENTRY_W-1:0]     wdata_i,
  input  logic [FIFO_ADDR_W-1:0] raddr_i,
  output logic [ENTRY_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 2 ** FIFO_ADDR_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_fifo.sv
// First-word-fall-through receive buffer behind the UART Rx block, with
// level/threshold interrupt and sticky overrun status.
module rx_fifo
  import rx_fifo_pkg::*;
#(
  parameter int unsigned FIFO_ADDR_W = RX_FIFO_ADDR_W
) (
  input  logic       clk_i,
  input  logic       rst_i,
  rx_fifo_if.slave   bus
);

  localparam int unsigned PTR_W = FIFO_ADDR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             ovr_q, ovr_d;
  logic             irq_q, irq_d;

  logic             empty_c, full_c;
  logic             push_c, pop_c, drop_c, we_c;
  rx_entry_t        wr_entry;
  logic [ENTRY_W-1:0] rd_raw;

  // Pointer MSB is the wrap bit: equal pointers = empty, only MSB differs = full
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[FIFO_ADDR_W-1:0] == rd_ptr_q[FIFO_ADDR_W-1:0]) &&
                   (wr_ptr_q[FIFO_ADDR_W] != rd_ptr_q[FIFO_ADDR_W]);

  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign pop_c  = bus.rd_en_i && !empty_c;
  assign push_c = bus.rx_done_i && (!full_c || pop_c);
  assign drop_c = bus.rx_done_i && full_c && !pop_c;

  assign wr_entry = pack_entry(bus.rx_stop_err_i, bus.rx_parity_err_i, bus.rx_data_i);

  rx_fifo_ram #(
    .ENTRY_W     (ENTRY_W),
    .FIFO_ADDR_W (FIFO_ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (we_c),
    .waddr_i (wr_ptr_q[FIFO_ADDR_W-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q[FIFO_ADDR_W-1:0]),
    .rdata_o (rd_raw)
  );

  // Next-state: flush overrides push, pop and overrun updates
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    we_c     = 1'b0;

    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovr_d    = 1'b0;
    end else begin
      if (push_c) begin
        we_c     = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + PTR_W'(1);
        2'b01:   count_d = count_q - PTR_W'(1);
        default: count_d = count_q;
      endcase
      if (drop_c) begin
        ovr_d = 1'b1;
      end else if (bus.ovr_clr_i) begin
        ovr_d = 1'b0;
      end
    end

    irq_d = (bus.threshold_i != '0) && (count_d >= bus.threshold_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      irq_q    <= irq_d;
    end
  end

  // Head entry falls through; an empty FIFO presents zeros
  assign bus.rd_data_o       = empty_c ? '0   : rd_raw[DATA_LSB +: MAX_UART_DATA_W];
  assign bus.rd_parity_err_o = empty_c ? 1'b0 : rd_raw[PERR_BIT];
  assign bus.rd_stop_err_o   = empty_c ? 1'b0 : rd_raw[SERR_BIT];
  assign bus.empty_o         = empty_c;
  assign bus.full_o          = full_c;
  assign bus.count_o         = count_q;
  assign bus.level_irq_o     = irq_q;
  assign bus.overrun_o       = ovr_q;

endmodule
